// File: rtl/joypad_pkg.sv
// joypad_pkg: shared constants, button word type and dpad filter for the joypad serializer
package joypad_pkg;
    localparam int SHIFT_LEN = 24;
    localparam logic [7:0] SIG_PORT1 = 8'h08;
    localparam logic [7:0] SIG_PORT2 = 8'h04;
    localparam int BTN_A = 0;
    localparam int BTN_B = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START = 3;
    localparam int BTN_UP = 4;
    localparam int BTN_DOWN = 5;
    localparam int BTN_LEFT = 6;
    localparam int BTN_RIGHT = 7;

    typedef logic [7:0] pad_t;

    function automatic pad_t filter_dpad(input pad_t p);
        pad_t r;
        r = p;
        if (p[BTN_LEFT] && p[BTN_RIGHT]) begin
            r[BTN_LEFT] = 1'b0;
            r[BTN_RIGHT] = 1'b0;
        end
        if (p[BTN_UP] && p[BTN_DOWN]) begin
            r[BTN_UP] = 1'b0;
            r[BTN_DOWN] = 1'b0;
        end
        return r;
    endfunction
endpackage

// File: rtl/joypad_port.sv
// joypad_port: one NES controller port -- reload on strobe, shift right with 1-fill on read-clock falling edge
module joypad_port
    import joypad_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 strobe,
    input  logic                 rd_clk,
    input  logic [SHIFT_LEN-1:0] reload_word,
    output logic                 data
);
    logic [SHIFT_LEN-1:0] shift_reg;
    logic                 rd_clk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            rd_clk_q  <= 1'b0;
        end else begin
            rd_clk_q <= rd_clk;
            if (strobe)
                shift_reg <= reload_word;
            else if (rd_clk_q && !rd_clk)
                shift_reg <= {1'b1, shift_reg[SHIFT_LEN-1:1]};
        end
    end

    assign data = shift_reg[0];
endmodule

// File: rtl/joypad_serializer.sv
// joypad_serializer: NES $4016/$4017 pad serializer with Four Score framing; turbo under `JOYPAD_TURBO_EN
module joypad_serializer
    import joypad_pkg::*;
#(
    parameter int NUM_PADS          = 4,
    parameter int TURBO_HALF_PERIOD = 715909
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PADS*8-1:0] pad_buttons,
    input  logic                  multitap_en,
    input  logic [NUM_PADS*2-1:0] turbo_mask,
    input  logic [2:0]            joypad_out,
    input  logic [1:0]            joypad_clock,
    output logic [4:0]            joypad1_data,
    output logic [4:0]            joypad2_data
);
    logic                 strobe;
    logic                 mode;
    logic                 mode_next;
    pad_t                 pads [4];
    logic [SHIFT_LEN-1:0] word1;
    logic [SHIFT_LEN-1:0] word2;
    logic                 data1;
    logic                 data2;
    logic                 unused_inputs;

    assign strobe = joypad_out[0];
    assign unused_inputs = ^{joypad_out[2:1], turbo_mask, multitap_en, TURBO_HALF_PERIOD[0]};

`ifdef JOYPAD_TURBO_EN
    localparam int CW = $clog2(TURBO_HALF_PERIOD);
    logic [CW-1:0] turbo_cnt;
    logic          phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            turbo_cnt <= '0;
            phase     <= 1'b1;
        end else if (turbo_cnt == CW'(TURBO_HALF_PERIOD - 1)) begin
            turbo_cnt <= '0;
            phase     <= ~phase;
        end else begin
            turbo_cnt <= turbo_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        for (int n = 0; n < 4; n++) pads[n] = '0;
        for (int n = 0; n < NUM_PADS; n++) begin
            pads[n] = filter_dpad(pad_buttons[8*n +: 8]);
`ifdef JOYPAD_TURBO_EN
            pads[n][BTN_A] = pads[n][BTN_A] & (phase | ~turbo_mask[2*n]);
            pads[n][BTN_B] = pads[n][BTN_B] & (phase | ~turbo_mask[2*n+1]);
`endif
        end
    end

    // mode only changes on a reload, so the word loaded this cycle already reflects it
    assign mode_next = strobe ? (multitap_en && NUM_PADS == 4) : mode;
    assign word1 = mode_next ? {SIG_PORT1, pads[2], pads[0]} : {16'hFFFF, pads[0]};
    assign word2 = mode_next ? {SIG_PORT2, pads[3], pads[1]} : {16'hFFFF, pads[1]};

    always_ff @(posedge clk) begin
        if (reset)
            mode <= 1'b0;
        else
            mode <= mode_next;
    end

    joypad_port u_port1 (
        .clk(clk), .reset(reset), .strobe(strobe), .rd_clk(joypad_clock[0]),
        .reload_word(word1), .data(data1)
    );

    joypad_port u_port2 (
        .clk(clk), .reset(reset), .strobe(strobe), .rd_clk(joypad_clock[1]),
        .reload_word(word2), .data(data2)
    );

    assign joypad1_data = {4'b0, data1};
    assign joypad2_data = {4'b0, data2};
endmodule

// File: tb/tb_joypad_serializer.sv
// tb_joypad_serializer: frame tables, hand corner cases and random traffic against a frame/read-count model
module tb_joypad_serializer;
    localparam int TP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pad_buttons = '0;
    logic        multitap_en = 1'b0;
    logic [7:0]  turbo_mask = '0;
    logic [2:0]  joypad_out = '0;
    logic [1:0]  joypad_clock = '0;
    logic [4:0]  joypad1_data;
    logic [4:0]  joypad2_data;

    int n_checks = 0;
    int n_fail = 0;

    joypad_serializer #(.NUM_PADS(4), .TURBO_HALF_PERIOD(TP)) dut (
        .clk(clk), .reset(reset), .pad_buttons(pad_buttons), .multitap_en(multitap_en),
        .turbo_mask(turbo_mask), .joypad_out(joypad_out), .joypad_clock(joypad_clock),
        .joypad1_data(joypad1_data), .joypad2_data(joypad2_data)
    );

    always #5 clk = ~clk;

    logic [23:0] m_word [2] = '{24'h0, 24'h0};
    int          m_cnt [2] = '{0, 0};
    logic [1:0]  m_prev = '0;
    int          m_t = 0;

    function automatic logic [7:0] ref_pad(int n);
        logic [7:0] p;
        bit ph;
        p = pad_buttons[8*n +: 8];
        if (p[7] && p[6]) p = p & 8'h3F;
        if (p[5] && p[4]) p = p & 8'hCF;
        ph = ((m_t / TP) % 2) == 0;
`ifdef JOYPAD_TURBO_EN
        if (turbo_mask[2*n] && !ph) p[0] = 1'b0;
        if (turbo_mask[2*n+1] && !ph) p[1] = 1'b0;
`endif
        return p;
    endfunction

    function automatic logic exp_bit(int k);
        return m_cnt[k] < 24 ? m_word[k][m_cnt[k]] : 1'b1;
    endfunction

    task automatic model_update();
        if (reset) begin
            m_word = '{24'h0, 24'h0};
            m_cnt = '{0, 0};
            m_prev = '0;
            m_t = 0;
        end else begin
            if (joypad_out[0]) begin
                m_word[0] = multitap_en ? {8'h08, ref_pad(2), ref_pad(0)} : {16'hFFFF, ref_pad(0)};
                m_word[1] = multitap_en ? {8'h04, ref_pad(3), ref_pad(1)} : {16'hFFFF, ref_pad(1)};
                m_cnt = '{0, 0};
            end else begin
                for (int k = 0; k < 2; k++)
                    if (m_prev[k] && !joypad_clock[k] && m_cnt[k] < 24) m_cnt[k]++;
            end
            m_prev = joypad_clock;
            m_t++;
        end
    endtask

    task automatic check(string name, logic [4:0] act, logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("model_p1", joypad1_data, {4'b0, exp_bit(0)});
        check("model_p2", joypad2_data, {4'b0, exp_bit(1)});
    endtask

    task automatic read(logic [1:0] which);
        joypad_clock = which;
        step();
        joypad_clock = 2'b00;
        step();
    endtask

    task automatic strobe_pulse();
        joypad_out = 3'b001;
        step();
        joypad_out = 3'b000;
        step();
    endtask

    typedef struct {
        logic [31:0] pads;
        logic        mode;
        logic [23:0] exp1;
        logic [23:0] exp2;
    } vec_t;

    vec_t tbl [4];

    initial begin
        tbl[0] = '{32'h0000_0001, 1'b0, 24'hFFFF01, 24'hFFFF00};
        tbl[1] = '{32'h0002_0081, 1'b1, 24'h080281, 24'h040000};
        tbl[2] = '{32'h0000_C0F3, 1'b0, 24'hFFFF03, 24'hFFFF00};
        tbl[3] = '{32'h50FF_3CA5, 1'b1, 24'h080FA5, 24'h04500C};

        step();
        step();
        check("reset_p1", joypad1_data, 5'b0);
        check("reset_p2", joypad2_data, 5'b0);
        reset = 1'b0;
        step();
        check("pre_strobe_p1", joypad1_data, 5'b0);

        for (int e = 0; e < 4; e++) begin
            pad_buttons = tbl[e].pads;
            multitap_en = tbl[e].mode;
            strobe_pulse();
            for (int i = 0; i < 26; i++) begin
                check("tbl_p1", joypad1_data, {4'b0, i < 24 ? tbl[e].exp1[i] : 1'b1});
                check("tbl_p2", joypad2_data, {4'b0, i < 24 ? tbl[e].exp2[i] : 1'b1});
                read(2'b11);
            end
        end

        multitap_en = 1'b0;
        pad_buttons = 32'h0000_0001;
        joypad_out = 3'b001;
        for (int i = 0; i < 5; i++) begin
            joypad_clock = 2'b01;
            step();
            check("strobe_hold", joypad1_data, 5'b00001);
            joypad_clock = 2'b00;
            step();
            check("strobe_hold", joypad1_data, 5'b00001);
        end
        joypad_out = 3'b000;
        step();

        pad_buttons = 32'h0000_0005;
        strobe_pulse();
        for (int i = 0; i < 3; i++) read(2'b01);
        check("pre_collide", joypad1_data, 5'b0);
        joypad_clock = 2'b01;
        step();
        joypad_out = 3'b001;
        joypad_clock = 2'b00;
        step();
        joypad_out = 3'b000;
        step();
        check("collide_a", joypad1_data, 5'b1);
        read(2'b01);
        check("collide_b", joypad1_data, 5'b0);
        read(2'b01);
        check("collide_sel", joypad1_data, 5'b1);

        pad_buttons = 32'h0000_0201;
        strobe_pulse();
        for (int i = 0; i < 3; i++) read(2'b11);
        reset = 1'b1;
        step();
        check("midrst_p1", joypad1_data, 5'b0);
        check("midrst_p2", joypad2_data, 5'b0);
        reset = 1'b0;
        strobe_pulse();
        check("midrst_a1", joypad1_data, 5'b1);
        check("midrst_a2", joypad2_data, 5'b0);
        read(2'b10);
        check("midrst_b2", joypad2_data, 5'b1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        pad_buttons = 32'h0000_0001;
        turbo_mask = 8'h01;
        joypad_out = 3'b001;
        for (int k = 0; k < 16; k++) begin
            step();
`ifdef JOYPAD_TURBO_EN
            check("turbo_a", joypad1_data, {4'b0, ((k / TP) % 2) == 0});
`else
            check("turbo_a", joypad1_data, 5'b1);
`endif
        end
        joypad_out = 3'b000;
        turbo_mask = '0;

        for (int c = 0; c < 1500; c++) begin
            pad_buttons = $urandom;
            multitap_en = 1'($urandom_range(0, 1));
            turbo_mask = 8'($urandom);
            joypad_out = {2'($urandom), $urandom_range(0, 39) == 0};
            joypad_clock = 2'($urandom);
            reset = $urandom_range(0, 299) == 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
